// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder sequencer.
// State encoding and counter sizing helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PASS1,
    PASS2,
    DONE
  } state_t;

  localparam int DEF_WIDTH = 8;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/half_adder_dataflow.sv
// Dataflow half-adder cell.
// Sole arithmetic element of the serial adder.
module half_adder_dataflow (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial ripple adder time-sharing one half-adder.
// Two half-adder passes per bit, valid/ready on both sides.
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  import serial_add_pkg::*;

  localparam int CW = cnt_width(WIDTH);

  state_t state;
  state_t state_n;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_nx;
  logic             c;
  logic             s1;
  logic             c1;
  logic             ha_x;
  logic             ha_y;
  logic             ha_s;
  logic             ha_c;
  logic             last;

  assign last = (cnt == CW'(WIDTH - 1));

  half_adder_dataflow u_ha (
    .x (ha_x),
    .y (ha_y),
    .s (ha_s),
    .c (ha_c)
  );

  // Pass 1 adds the operand bits; pass 2 folds in the running carry.
  always_comb begin
    ha_x = a_sr[0];
    ha_y = b_sr[0];
    if (state == PASS2) begin
      ha_x = s1;
      ha_y = c;
    end
  end

  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_nx = ha_s;
    end else begin : g_wn
      assign sum_nx = {ha_s, sum_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (in_valid) state_n = PASS1;
      PASS1:   state_n = PASS2;
      PASS2:   state_n = last ? DONE : PASS1;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      c      <= 1'b0;
      s1     <= 1'b0;
      c1     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr <= a;
            b_sr <= b;
            c    <= cin;
            cnt  <= '0;
          end
        end
        PASS1: begin
          s1 <= ha_s;
          c1 <= ha_c;
        end
        PASS2: begin
          sum_sr <= sum_nx;
          c      <= c1 | ha_c;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          if (!last) cnt <= cnt + CW'(1);
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_sr;
  assign cout      = c;

endmodule

// File: doc/serial_add_sequencer.md
# serial_add_sequencer

Time-shares one half-adder cell to perform a WIDTH-bit ripple addition with carry-in, one half-adder pass per cycle, two passes per bit. Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. This is the area-minimal adder option for low-throughput control paths: one half-adder plus shift registers instead of a WIDTH-bit adder.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (legal range ≥ 1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  sequencer can accept operands.
- a  input  WIDTH  addend A.
- b  input  WIDTH  addend B.
- cin  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry-out of the addition.
- busy  output  1  high in PASS1, PASS2 and DONE.

## Operation
- FSM states: IDLE, PASS1, PASS2, DONE.
- IDLE: in_ready = 1. On in_valid && in_ready, latch a, b and cin into the operand shift registers A_sr, B_sr and the carry register C. Clear the bit counter. Go to PASS1.
- PASS1 (bit i = counter): the half-adder inputs are (A_sr[0], B_sr[0]). Register its outputs as s1 and c1. Go to PASS2.
- PASS2: the half-adder inputs are (s1, C).
  - The result bit is the half-adder sum; shift it into the MSB end of the sum shift register.
  - C <= c1 | half-adder carry.
  - Shift A_sr and B_sr right by 1.
  - If counter == WIDTH-1, go to DONE. Otherwise increment the counter and go to PASS1.
- DONE: out_valid = 1. sum and cout (= C) are held stable. On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. in_ready is 0 in every non-IDLE state.
- A result is never dropped. A new operand is never accepted in the same cycle as the DONE→IDLE transition.
- Counter width: $clog2(WIDTH), minimum 1 bit.
- The half-adder input mux is selected by state only; it contains no arithmetic of its own.

## Timing
- Accepting edge E0 (IDLE with in_valid && in_ready).
- Each bit occupies 2 cycles.
- out_valid is high from edge E0 + 2·WIDTH onward. For WIDTH = 8, that is the 16th edge after acceptance.
- Result handshake: on the edge where out_valid && out_ready, the FSM returns to IDLE. in_ready is high in the following cycle.
- Minimum initiation interval: 2·WIDTH + 2 cycles.
- Reset, whether applied idle or mid-operation:
  - The next edge forces IDLE and clears the counter, shift registers and C.
  - out_valid = 0, sum = 0, cout = 0, busy = 0.
  - in_ready = 0 while rst is high and 1 in the first cycle after rst deasserts.
  - An in-flight operation is aborted and produces no out_valid.
- out_valid held with out_ready low: sum, cout and out_valid stay unchanged indefinitely.
- Simultaneous rst and handshake: rst wins.

## Structure
- Shared package serial_add_pkg: the state enum type (IDLE, PASS1, PASS2, DONE) and the localparam for the counter width function.
- Sub-module: one instance of the team's dataflow half-adder cell, half_adder_dataflow, as the only arithmetic element.
- Everything else is in the sequencer: FSM, counter, shift registers, input mux.

## Test plan
- WIDTH = 8, a = 0xFF, b = 0x01, cin = 0, out_ready = 1 → sum = 0x00, cout = 1. out_valid rises exactly 16 edges after acceptance and lasts 1 cycle.
- a = 0xA5, b = 0x5A, cin = 1 → sum = 0x00, cout = 1. Then a = 0x12, b = 0x34, cin = 0 → sum = 0x46, cout = 0. Back-to-back, in_valid held high: the second operand is accepted only when in_ready returns.
- Backpressure: out_ready low for 5 cycles after out_valid → sum, cout and out_valid stable throughout. The new in_valid pulses during this window are ignored.
- Reset asserted at cycle 7 of an operation → next cycle: busy = 0, out_valid = 0, sum = 0. No result ever appears for the aborted operands.
- WIDTH = 1 build: a = 1, b = 1, cin = 1 → sum = 1, cout = 1 after 2 edges.
- Randomized sanity sweep: 200 random (a, b, cin) at WIDTH = 8, each checked against {cout, sum} == a + b + cin.
